prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameters SHALL be:
- OPCODE, default 3, opcode field width.
- WIDTH_REG, default 8, data/instruction width.
- WIDTH_ADDRESS_BIT SHALL be derived as WIDTH_REG-OPCODE (5), giving DEPTH = 2**WIDTH_ADDRESS_BIT (32).

REQ-002 Ports SHALL be:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous active-low reset.
- in_valid  input  1  host byte valid.
- in_data  input  WIDTH_REG  host byte.
- in_ready  output  1  loader accepts byte.
- mem_wr  output  1  program-memory write strobe.
- mem_addr  output  WIDTH_ADDRESS_BIT  write address.
- mem_wdata  output  WIDTH_REG  write data.
- cpu_reset_n  output  1  CPU reset, low = CPU held.
- cpu_halt  input  1  CPU HALT.
- cpu_result  input  WIDTH_REG  CPU accumulator.
- result  output  WIDTH_REG  accumulator captured at halt.
- run_cycles  output  16  CPU cycles from release to halt.
- done  output  1  one-cycle pulse on halt.
- err  output  1  framing/checksum error flag.

Function
REQ-003 A byte SHALL be accepted on a rising edge with in_valid=1 and in_ready=1; in_data is sampled only then.
REQ-004 The frame SHALL be: SYNC byte 0xA5, length L, L payload bytes, XOR checksum of the payload bytes.
REQ-005 States SHALL be IDLE, LEN, LOAD, CHK, RUN, DONE, ERR.
REQ-006 State transitions SHALL be:
- IDLE: accepted 0xA5 goes to LEN; any other byte is accepted and discarded.
- LEN: accepted L with 1<=L<=32 goes to LOAD; L=0 or L>32 goes to ERR.
- LOAD: stays until L bytes are accepted, then goes to CHK.
- CHK: match goes to RUN; mismatch goes to ERR.
- RUN: cpu_halt=1 goes to DONE.
- DONE or ERR: accepted 0xA5 goes to LEN; other bytes are discarded.
REQ-007 in_ready SHALL be 1 in every state except RUN, where it is 0.
REQ-008 For payload byte k (0-based), the cycle after acceptance SHALL drive mem_wr=1 for exactly one cycle, with mem_addr=k and mem_wdata=byte; mem_wr SHALL be 0 at all other times.
REQ-009 Payload addresses SHALL start at 0 and SHALL NOT wrap (L<=32 guarantees this).
REQ-010 The XOR accumulator SHALL clear on entry to LEN and update on each accepted payload byte.
REQ-011 cpu_reset_n SHALL:
- go high the cycle after a matching checksum is accepted;
- stay high through RUN and DONE;
- go low the cycle after 0xA5 is accepted in DONE;
- be low in all other states.
REQ-012 run_cycles SHALL clear on entry to RUN and increment once per RUN cycle, saturating at 0xFFFF.
REQ-013 On the RUN cycle where cpu_halt=1:
- result SHALL register cpu_result;
- done SHALL pulse high on the next cycle;
- run_cycles SHALL freeze.
REQ-014 err SHALL set on entry to ERR and clear on acceptance of 0xA5.
REQ-015 cpu_halt SHALL be ignored outside RUN.
REQ-016 If cpu_halt is high on the first RUN cycle, the block SHALL go to DONE with run_cycles=1.
REQ-017 Sync byte 0xA5 appearing inside LEN, LOAD or CHK SHALL be treated as data, not as a restart.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 On reset low, asynchronously:
- state=IDLE;
- in_ready=1;
- mem_wr=0, mem_addr=0, mem_wdata=0;
- cpu_reset_n=0;
- result=0, run_cycles=0;
- done=0, err=0;
- byte index=0, XOR accumulator=0.
REQ-020 Reset mid-frame SHALL abandon the frame; memory words already written are not cleared.

Structure
REQ-021 A shared package SHALL hold:
- the state enum;
- SYNC_BYTE (0xA5);
- the derived WIDTH_ADDRESS_BIT/DEPTH constants, shared with the CPU memory.
REQ-022 The saturating run counter SHALL be the one sub-module, sat_counter (width 16, clear/enable inputs); all other logic SHALL be in prog_loader.

Verification
REQ-023 Load and run: frame A5,03,21,42,E0,checksum 83 -> three one-cycle mem_wr pulses (addr 0,1,2; data 21,42,E0); cpu_reset_n rises after the checksum; with cpu_halt driven at cycle 10 and cpu_result=0x5A -> result=0x5A, done pulses once, run_cycles=10.
REQ-024 Bad checksum: A5,02,11,22,00 -> err=1, cpu_reset_n stays 0; then A5,01,07,07 -> err clears and RUN is entered.
REQ-025 Length bounds: L=0 -> ERR; L=33 -> ERR, no mem_wr; L=32 with 32 bytes -> addresses 0..31 each written once.
REQ-026 Flow control: garbage bytes 00,FF before A5 are discarded; in_valid toggled randomly during LOAD -> writes only on handshakes; in_ready=0 throughout RUN.
REQ-027 Reset mid-LOAD after 2 of 4 bytes -> all outputs return to reset values; a following full frame loads correctly.
REQ-028 Watchdog: no cpu_halt for 70000 cycles -> run_cycles saturates at 0xFFFF; DONE then A5 -> cpu_reset_n goes low the next cycle.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared constants and types for the program loader and the CPU program memory.
`default_nettype none

package prog_loader_pkg;

  localparam int DEF_OPCODE    = 3;
  localparam int DEF_WIDTH_REG = 8;
  localparam int RUN_CNT_W     = 16;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  function automatic int addr_width(input int width_reg, input int opcode);
    return width_reg - opcode;
  endfunction

  localparam int WIDTH_ADDRESS_BIT = addr_width(DEF_WIDTH_REG, DEF_OPCODE);
  localparam int DEPTH             = 2 ** WIDTH_ADDRESS_BIT;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_LOAD = 3'd2,
    ST_CHK  = 3'd3,
    ST_RUN  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } pl_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_loader_if.sv
// Host byte stream, program-memory write port and CPU control/status bundle.
`default_nettype none

interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int WIDTH_REG = DEF_WIDTH_REG,
  parameter int WIDTH_AB  = WIDTH_ADDRESS_BIT
);

  logic                 in_valid;
  logic [WIDTH_REG-1:0] in_data;
  logic                 in_ready;
  logic                 mem_wr;
  logic [WIDTH_AB-1:0]  mem_addr;
  logic [WIDTH_REG-1:0] mem_wdata;
  logic                 cpu_reset_n;
  logic                 cpu_halt;
  logic [WIDTH_REG-1:0] cpu_result;
  logic [WIDTH_REG-1:0] result;
  logic [RUN_CNT_W-1:0] run_cycles;
  logic                 done;
  logic                 err;

  // Host / CPU side
  modport master (
    output in_valid, in_data, cpu_halt, cpu_result,
    input  in_ready, mem_wr, mem_addr, mem_wdata, cpu_reset_n,
    input  result, run_cycles, done, err
  );

  // Loader side
  modport slave (
    input  in_valid, in_data, cpu_halt, cpu_result,
    output in_ready, mem_wr, mem_addr, mem_wdata, cpu_reset_n,
    output result, run_cycles, done, err
  );

endinterface

`default_nettype wire

// File: rtl/prog_loader_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_clr,
  input  wire logic             i_en,
  output logic [WIDTH-1:0]      o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// Framed program loader: receives SYNC/len/payload/XOR frames, writes program
// memory, releases the CPU and measures how long it runs until HALT.
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int OPCODE    = DEF_OPCODE,
  parameter int WIDTH_REG = DEF_WIDTH_REG
) (
  input  wire logic    clk,
  input  wire logic    reset,
  prog_loader_if.slave bus
);

  localparam int ADDR_W    = addr_width(WIDTH_REG, OPCODE);
  localparam int MEM_DEPTH = 2 ** ADDR_W;
  localparam int IDX_W     = ADDR_W + 1;

  pl_state_t            r_state;
  logic                 r_in_ready;
  logic                 r_mem_wr;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [WIDTH_REG-1:0] r_mem_wdata;
  logic                 r_cpu_reset_n;
  logic [WIDTH_REG-1:0] r_result;
  logic                 r_done;
  logic                 r_err;
  logic [IDX_W-1:0]     r_len;
  logic [IDX_W-1:0]     r_idx;
  logic [WIDTH_REG-1:0] r_xor;

  logic                 w_accept;
  logic                 w_is_sync;
  logic                 w_len_ok;
  logic                 w_last;
  logic                 w_csum_ok;
  logic                 w_cnt_clr;
  logic                 w_cnt_en;
  logic [RUN_CNT_W-1:0] w_run_cycles;

  assign w_accept  = bus.in_valid & r_in_ready;
  assign w_is_sync = (bus.in_data == WIDTH_REG'(SYNC_BYTE));
  assign w_len_ok  = (bus.in_data != '0) && (bus.in_data <= WIDTH_REG'(MEM_DEPTH));
  assign w_last    = ((r_idx + IDX_W'(1)) == r_len);
  assign w_csum_ok = (bus.in_data == r_xor);
  assign w_cnt_clr = (r_state == ST_CHK) && w_accept && w_csum_ok;
  assign w_cnt_en  = (r_state == ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_in_ready    <= 1'b1;
      r_mem_wr      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_cpu_reset_n <= 1'b0;
      r_result      <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_len         <= '0;
      r_idx         <= '0;
      r_xor         <= '0;
    end else begin
      r_mem_wr <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          // Non-sync bytes are swallowed here; only 0xA5 opens a frame.
          if (w_accept && w_is_sync) begin
            r_state       <= ST_LEN;
            r_xor         <= '0;
            r_err         <= 1'b0;
            r_cpu_reset_n <= 1'b0;
          end
        end
        ST_LEN: begin
          if (w_accept) begin
            if (w_len_ok) begin
              r_len   <= bus.in_data[IDX_W-1:0];
              r_idx   <= '0;
              r_state <= ST_LOAD;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_ERR;
            end
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_mem_wr    <= 1'b1;
            r_mem_addr  <= r_idx[ADDR_W-1:0];
            r_mem_wdata <= bus.in_data;
            r_xor       <= r_xor ^ bus.in_data;
            r_idx       <= r_idx + IDX_W'(1);
            if (w_last) begin
              r_state <= ST_CHK;
            end
          end
        end
        ST_CHK: begin
          if (w_accept) begin
            if (w_csum_ok) begin
              r_state       <= ST_RUN;
              r_cpu_reset_n <= 1'b1;
              r_in_ready    <= 1'b0;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_ERR;
            end
          end
        end
        ST_RUN: begin
          if (bus.cpu_halt) begin
            r_result   <= bus.cpu_result;
            r_done     <= 1'b1;
            r_in_ready <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Counts every RUN cycle including the halting one, so a halt on the
  // first RUN cycle reports 1.
  sat_counter #(
    .WIDTH (RUN_CNT_W)
  ) u_run_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .o_count (w_run_cycles)
  );

  assign bus.in_ready    = r_in_ready;
  assign bus.mem_wr      = r_mem_wr;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.cpu_reset_n = r_cpu_reset_n;
  assign bus.result      = r_result;
  assign bus.run_cycles  = w_run_cycles;
  assign bus.done        = r_done;
  assign bus.err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes and halt results are
// queued at stimulus time and retired by a negedge monitor.
`default_nettype none

module tb_prog_loader;

  logic clk;
  logic reset;

  prog_loader_if bus ();

  prog_loader #(
    .OPCODE    (3),
    .WIDTH_REG (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  res;
    logic [15:0] cyc;
  } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] pl [64];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Retire expected writes and halt results as the DUT produces them.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.mem_wr) begin
        if (wr_q.size() == 0) begin
          check_eq("mem_wr_unexpected", 32'd1, 32'd0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check_eq("mem_addr", 32'(bus.mem_addr), 32'(w.addr));
          check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(w.data));
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          check_eq("done_unexpected", 32'd1, 32'd0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          check_eq("result", 32'(bus.result), 32'(d.res));
          check_eq("run_cycles", 32'(bus.run_cycles), 32'(d.cyc));
        end
      end
    end
  end

  // Called and returns at a negedge; byte is accepted on the posedge in between.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    int t;
    if (gaps) begin
      int k;
      k = $urandom_range(0, 2);
      bus.in_valid = 1'b0;
      for (int i = 0; i < k; i++) begin
        bus.in_data = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    forever begin
      acc = bus.in_ready;
      @(posedge clk);
      if (acc) break;
      t++;
      if (t > 100) begin
        check_eq("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic load_frame(input int n, input bit gaps);
    logic [7:0] x;
    logic [7:0] nb;
    x  = 8'h00;
    nb = n[7:0];
    send_byte(8'hA5, 1'b0);
    send_byte(nb, 1'b0);
    for (int i = 0; i < n; i++) begin
      wr_q.push_back('{addr: i[4:0], data: pl[i]});
      x = x ^ pl[i];
      send_byte(pl[i], gaps);
    end
    check_eq("cpu_rst_n_pre_chk", 32'(bus.cpu_reset_n), 32'd0);
    send_byte(x, 1'b0);
  endtask

  task automatic run_cpu(input int n, input logic [7:0] res, input bit chk_rdy, input logic [15:0] exp_cyc);
    check_eq("cpu_rst_n_run", 32'(bus.cpu_reset_n), 32'd1);
    for (int c = 1; c <= n; c++) begin
      if (chk_rdy) check_eq("in_ready_run", 32'(bus.in_ready), 32'd0);
      if (c == n) begin
        bus.cpu_halt   = 1'b1;
        bus.cpu_result = res;
        done_q.push_back('{res: res, cyc: exp_cyc});
      end
      @(negedge clk);
    end
    bus.cpu_halt   = 1'b0;
    bus.cpu_result = 8'($urandom);
    check_eq("cpu_rst_n_done", 32'(bus.cpu_reset_n), 32'd1);
    check_eq("in_ready_done", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check_eq({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check_eq({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check_eq({tag, "_cpu_rst_n"}, 32'(bus.cpu_reset_n), 32'd0);
    check_eq({tag, "_result"}, 32'(bus.result), 32'd0);
    check_eq({tag, "_run_cycles"}, 32'(bus.run_cycles), 32'd0);
    check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.cpu_halt   = 1'b0;
    bus.cpu_result = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;

    // HALT outside RUN must not produce done
    bus.cpu_halt = 1'b1;
    repeat (3) @(negedge clk);
    bus.cpu_halt = 1'b0;

    // Garbage before sync, then basic load and run
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    pl[0] = 8'h21; pl[1] = 8'h42; pl[2] = 8'hE0;
    load_frame(3, 1'b0);
    run_cpu(10, 8'h5A, 1'b1, 16'd10);

    // Bad checksum from DONE: sync drops CPU reset immediately
    send_byte(8'hA5, 1'b0);
    check_eq("cpu_rst_n_after_sync", 32'(bus.cpu_reset_n), 32'd0);
    send_byte(8'h02, 1'b0);
    wr_q.push_back('{addr: 5'd0, data: 8'h11});
    send_byte(8'h11, 1'b0);
    wr_q.push_back('{addr: 5'd1, data: 8'h22});
    send_byte(8'h22, 1'b0);
    send_byte(8'h00, 1'b0);
    check_eq("err_bad_csum", 32'(bus.err), 32'd1);
    check_eq("cpu_rst_n_bad_csum", 32'(bus.cpu_reset_n), 32'd0);
    send_byte(8'hA5, 1'b0);
    check_eq("err_cleared", 32'(bus.err), 32'd0);
    send_byte(8'h01, 1'b0);
    wr_q.push_back('{addr: 5'd0, data: 8'h07});
    send_byte(8'h07, 1'b0);
    send_byte(8'h07, 1'b0);
    run_cpu(1, 8'h3C, 1'b1, 16'd1);

    // Length bounds
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    check_eq("err_len0", 32'(bus.err), 32'd1);
    send_byte(8'hA5, 1'b0);
    check_eq("err_len0_clr", 32'(bus.err), 32'd0);
    send_byte(8'd33, 1'b0);
    check_eq("err_len33", 32'(bus.err), 32'd1);
    for (int i = 0; i < 33; i++) send_byte(8'(i), 1'b0);
    check_eq("err_len33_hold", 32'(bus.err), 32'd1);

    // Full-depth frame with sync byte inside payload and random valid gaps
    for (int i = 0; i < 32; i++) pl[i] = 8'((i * 37) + 11);
    pl[5] = 8'hA5;
    load_frame(32, 1'b1);
    run_cpu(3, 8'hC3, 1'b1, 16'd3);

    // Reset in the middle of LOAD
    send_byte(8'hA5, 1'b0);
    send_byte(8'h04, 1'b0);
    wr_q.push_back('{addr: 5'd0, data: 8'h99});
    send_byte(8'h99, 1'b0);
    wr_q.push_back('{addr: 5'd1, data: 8'h88});
    send_byte(8'h88, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("mid");
    @(negedge clk);
    reset = 1'b1;
    pl[0] = 8'h10; pl[1] = 8'h20; pl[2] = 8'h30; pl[3] = 8'h4F;
    load_frame(4, 1'b0);
    run_cpu(5, 8'hE7, 1'b1, 16'd5);

    // Watchdog: counter saturates, then sync from DONE drops CPU reset
    pl[0] = 8'h6B;
    load_frame(1, 1'b0);
    run_cpu(70000, 8'h77, 1'b0, 16'hFFFF);
    send_byte(8'hA5, 1'b0);
    check_eq("cpu_rst_n_wd_sync", 32'(bus.cpu_reset_n), 32'd0);

    repeat (3) @(negedge clk);
    check_eq("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check_eq("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
